pack_telemetry: RTL and testbench

Transmit-side framer for the serial telemetry link. Accepts an 11-byte telemetry word as a single-cycle strobe and serializes it, LSB byte first, as one K comma followed by 11 data bytes into the 8b10b encoder, paced by the encoder's byte strobe. Between frames it emits K filler, so the receive-side unpacker always sees the K it needs before each frame and the trailing K it needs to release the last byte.

---
 rtl/pack_telemetry_pkg.sv | 13 +
 rtl/pack_telemetry_if.sv | 25 ++
 rtl/pack_telemetry.sv | 103 ++++++++++
 tb/tb_pack_telemetry.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pack_telemetry_pkg.sv
// Shared telemetry definitions: K comma, word size in bytes and the framer/unpacker state encoding.
package pack_telemetry_pkg;

  localparam logic [7:0]  K28_5       = 8'hBC;
  localparam int unsigned TELEM_BYTES = 11;
  localparam int unsigned TELEM_BITS  = TELEM_BYTES * 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } telem_state_t;

endpackage

// File: rtl/pack_telemetry_if.sv
// Telemetry word input and encoder byte output of the transmit framer.
interface pack_telemetry_if;
  import pack_telemetry_pkg::*;

  logic [TELEM_BITS-1:0] data_in;
  logic                  valid_in;
  logic                  tx_en;
  logic [7:0]            data_out;
  logic                  k_out;
  logic                  valid_out;
  logic                  busy;
  logic                  overflow;
  logic [15:0]           drop_cnt;

  modport master (
    output data_in, valid_in, tx_en,
    input  data_out, k_out, valid_out, busy, overflow, drop_cnt
  );

  modport slave (
    input  data_in, valid_in, tx_en,
    output data_out, k_out, valid_out, busy, overflow, drop_cnt
  );

endinterface

// File: rtl/pack_telemetry.sv
// Transmit-side framer: one K comma then 11 data bytes LSB first per word, K filler between frames,
// paced by the encoder byte strobe, with a one-entry pending buffer and a saturating drop counter.
module pack_telemetry
  import pack_telemetry_pkg::*;
#(
  parameter int unsigned g_data_width = TELEM_BYTES,
  parameter logic [7:0]  g_k_char     = K28_5
) (
  input logic             clk,
  input logic             rst,
  pack_telemetry_if.slave bus
);

  if (g_data_width != TELEM_BYTES) begin : g_bad_width
    $fatal(1, "pack_telemetry: g_data_width must be 11");
  end

  localparam logic [3:0] LAST_IDX = 4'(TELEM_BYTES - 1);

  telem_state_t          r_state;
  logic [TELEM_BITS-1:0] r_pend;
  logic                  r_pend_full;
  logic [TELEM_BITS-1:0] r_shift;
  logic [3:0]            r_idx;
  logic [7:0]            r_data_out;
  logic                  r_k_out;
  logic                  r_valid_out;
  logic                  r_overflow;
  logic [15:0]           r_drop_cnt;
  logic                  w_consume;

  // Pending word is taken only by the frame-start K slot in IDLE.
  assign w_consume = bus.tx_en && (r_state == ST_IDLE) && r_pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_overflow <= 1'b0;
      if (bus.valid_in && (!r_pend_full || w_consume)) begin
        r_pend      <= bus.data_in;
        r_pend_full <= 1'b1;
      end else begin
        if (w_consume) begin
          r_pend_full <= 1'b0;
        end
        if (bus.valid_in) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_data_out  <= '0;
      r_k_out     <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= bus.tx_en;
      if (bus.tx_en) begin
        case (r_state)
          ST_IDLE: begin
            r_data_out <= g_k_char;
            r_k_out    <= 1'b1;
            if (r_pend_full) begin
              r_shift <= r_pend;
              r_idx   <= '0;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_data_out <= r_shift[7:0];
            r_k_out    <= 1'b0;
            r_shift    <= r_shift >> 8;
            r_idx      <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.k_out     = r_k_out;
  assign bus.valid_out = r_valid_out;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.busy      = (r_state == ST_DATA) || r_pend_full;

endmodule

// File: tb/tb_pack_telemetry.sv
// Bench for pack_telemetry: directed scenarios plus random traffic against a byte-queue reference model.
module tb_pack_telemetry;
  import pack_telemetry_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pack_telemetry_if bus ();

  pack_telemetry #(
    .g_data_width(11),
    .g_k_char    (8'hBC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a queue of frame bytes still owed to the encoder and an optional pending word.
  logic [7:0]  m_frame[$];
  logic [87:0] m_pend;
  bit          m_pend_full;
  logic [7:0]  m_data;
  logic        m_k;
  logic        m_valid;
  logic        m_ovf;
  logic [15:0] m_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_pend      = '0;
    m_pend_full = 0;
    m_data      = '0;
    m_k         = 1'b0;
    m_valid     = 1'b0;
    m_ovf       = 1'b0;
    m_drop      = '0;
  endtask

  task automatic model_edge(input logic v, input logic [87:0] d, input logic te);
    bit consume;
    consume = te && (m_frame.size() == 0) && m_pend_full;
    m_ovf   = 1'b0;
    m_valid = te;
    if (te) begin
      if (m_frame.size() != 0) begin
        m_data = m_frame.pop_front();
        m_k    = 1'b0;
      end else begin
        m_data = 8'hBC;
        m_k    = 1'b1;
        if (m_pend_full) begin
          for (int i = 0; i < 11; i++) m_frame.push_back(m_pend[8*i +: 8]);
        end
      end
    end
    if (v && (!m_pend_full || consume)) begin
      m_pend      = d;
      m_pend_full = 1;
    end else begin
      if (consume) m_pend_full = 0;
      if (v) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check_eq("data_out",  32'(bus.data_out),  32'(m_data));
    check_eq("k_out",     32'(bus.k_out),     32'(m_k));
    check_eq("overflow",  32'(bus.overflow),  32'(m_ovf));
    check_eq("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    check_eq("busy",      32'(bus.busy),      32'((m_frame.size() != 0) || m_pend_full));
  endtask

  task automatic cycle(input logic v, input logic [87:0] d, input logic te);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.tx_en    = te;
    @(posedge clk);
    model_edge(v, d, te);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    bus.valid_in = 1'b0;
    bus.tx_en    = 1'b0;
    rst          = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  function automatic logic [87:0] rand_word();
    logic [87:0] w;
    for (int i = 0; i < 11; i++) w[8*i +: 8] = 8'($urandom_range(255, 0));
    return w;
  endfunction

  logic [87:0] w_fixed;
  logic [7:0]  seen[$];

  initial begin
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.tx_en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Single word, tx_en every cycle; also record the byte stream against the literal sequence.
    w_fixed = 88'h0A_0908_0706_0504_0302_01FF;
    cycle(1'b1, w_fixed, 1'b0);
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.valid_out) seen.push_back(bus.data_out);
    end
    begin
      logic [7:0] exp_seq[14];
      exp_seq = '{8'hBC, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hBC, 8'hBC};
      for (int i = 0; i < 14; i++) check_eq("seq_byte", 32'(seen[i]), 32'(exp_seq[i]));
    end

    // Two words three cycles apart.
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, rand_word(), 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b1);

    // Three words within one frame time: the third is dropped.
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, rand_word(), 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b1);
    check_eq("drop_after_three", 32'(bus.drop_cnt), 32'd1);

    // Same-cycle consume and accept at an IDLE tx_en.
    cycle(1'b1, rand_word(), 1'b0);
    cycle(1'b1, rand_word(), 1'b1);
    repeat (30) cycle(1'b0, '0, 1'b1);

    // tx_en every 4th cycle.
    cycle(1'b1, w_fixed, 1'b0);
    for (int c = 0; c < 60; c++) cycle(1'b0, '0, (c % 4) == 3);

    // Reset after byte 5 of a frame.
    cycle(1'b1, rand_word(), 1'b1);
    repeat (7) cycle(1'b0, '0, 1'b1);
    async_reset();
    repeat (15) cycle(1'b0, '0, 1'b1);

    // Drop counter saturation with the pending word held (no tx_en).
    cycle(1'b1, rand_word(), 1'b0);
    for (int c = 0; c < 65540; c++) cycle(1'b1, '0, 1'b0);
    check_eq("drop_sat", 32'(bus.drop_cnt), 32'h0000_FFFF);
    cycle(1'b1, '0, 1'b0);
    check_eq("ovf_at_sat", 32'(bus.overflow), 32'd1);
    repeat (20) cycle(1'b0, '0, 1'b1);

    // Random traffic with occasional reset.
    async_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(999, 0) == 0) async_reset();
      else cycle($urandom_range(15, 0) == 0, rand_word(), $urandom_range(3, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
